// File: rtl/sim_ram_2p.sv
// sim_ram_2p: simulation model of a simple dual-port SRAM (one write port,
// one read port, single clock domain).
// Ports:
//   clk, rst_n                   clock (posedge) and async active-low reset
//   wr_en/wr_addr/wr_mask/wr_data write port, per-lane (BW-bit) write enables
//   rd_en/rd_addr                read request, sampled into an RD_LAT-deep pipe
//   rd_valid/rd_data             registered read result, data held between reads
//   oor_err                      one-cycle pulse after an out-of-range access
module sim_ram_2p #(
  parameter int unsigned DP           = 512,
  parameter int unsigned DW           = 32,
  parameter int unsigned BW           = 8,
  parameter int unsigned AW           = 9,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned RDW_MODE     = 0,
  parameter int unsigned FORCE_X2ZERO = 0,
  parameter string       INIT_FILE    = "",
  localparam int unsigned LW          = (BW == 0) ? 1 : BW,
  localparam int unsigned MW          = (DW + LW - 1) / LW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [MW-1:0] wr_mask,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          oor_err
);

  // Clamped so an illegal RD_LAT still elaborates far enough to hit the check.
  localparam int unsigned LAT = (RD_LAT < 1) ? 1 : ((RD_LAT > 4) ? 4 : RD_LAT);
  localparam int unsigned IW  = (DP > 1) ? $clog2(DP) : 1;

  logic [DW-1:0] mem    [DP];
  logic          pipe_v [LAT];
  logic [DW-1:0] pipe_d [LAT];

  logic          wr_ok_c;
  logic          rd_ok_c;
  logic          rdw_hit_c;
  logic [IW-1:0] wr_idx_c;
  logic [IW-1:0] rd_idx_c;
  logic [DW-1:0] lane_bits_c;
  logic [DW-1:0] wr_word_c;
  logic [DW-1:0] rd_word_c;
  logic [DW-1:0] rd_sample_c;

`ifndef SYNTHESIS
  // Parameter sanity.
  initial begin
    if (RD_LAT < 1 || RD_LAT > 4) $fatal(1, "sim_ram_2p: RD_LAT=%0d outside 1..4", RD_LAT);
    if (BW == 0) $fatal(1, "sim_ram_2p: BW must be non-zero");
  end

  function automatic logic [DW-1:0] x2zero(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    for (int unsigned i = 0; i < DW; i++) r[i] = (v[i] === 1'b1);
    return r;
  endfunction
`endif

  // Expand lane mask to bit mask; the top lane is naturally truncated at DW-1.
  for (genvar b = 0; b < DW; b++) begin : g_lane_bits
    assign lane_bits_c[b] = wr_mask[b / LW];
  end

  // Address decode, merged write word and read-during-write selection.
  always_comb begin
    wr_ok_c   = wr_en && (64'(wr_addr) < 64'(DP));
    rd_ok_c   = rd_en && (64'(rd_addr) < 64'(DP));
    wr_idx_c  = IW'(wr_addr);
    rd_idx_c  = IW'(rd_addr);
    rdw_hit_c = wr_ok_c && rd_ok_c && (wr_addr == rd_addr);
    wr_word_c = (mem[wr_idx_c] & ~lane_bits_c) | (wr_data & lane_bits_c);
    rd_word_c = rd_ok_c ? mem[rd_idx_c] : '0;
    if ((RDW_MODE != 0) && rdw_hit_c) rd_word_c = wr_word_c;
  end

  // Optional X scrubbing of the sampled read word (simulation only).
  always_comb begin
    rd_sample_c = rd_word_c;
`ifndef SYNTHESIS
    if (FORCE_X2ZERO != 0) rd_sample_c = x2zero(rd_word_c);
`endif
  end

  // Memory write, read pipeline and out-of-range flag; contents survive reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < LAT; k++) begin
        pipe_v[k] <= 1'b0;
        pipe_d[k] <= '0;
      end
      oor_err <= 1'b0;
    end else begin
      if (wr_ok_c) mem[wr_idx_c] <= wr_word_c;
      pipe_v[0] <= rd_en;
      if (rd_en) pipe_d[0] <= rd_sample_c;
      // Data only advances with a valid so the last stage holds between reads.
      for (int unsigned k = 1; k < LAT; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        if (pipe_v[k-1]) pipe_d[k] <= pipe_d[k-1];
      end
      oor_err <= (wr_en && !wr_ok_c) || (rd_en && !rd_ok_c);
    end
  end

  assign rd_valid = pipe_v[LAT-1];
  assign rd_data  = pipe_d[LAT-1];

endmodule
